// File: rtl/exception_ctrl_pkg.sv
// Shared definitions for the exception controller: cause width, cause codes and FSM encoding.
package exception_ctrl_pkg;

   localparam int unsigned ExceptionCauseWidth = 6;

   localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_INT = 6'h00;
   localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_ALE = 6'h09;
   localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_SYS = 6'h0B;
   localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_BRK = 6'h0C;
   localparam logic [ExceptionCauseWidth-1:0] EXCEPTION_INE = 6'h0D;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StFlush    = 2'd1,
      StRedirect = 2'd2
   } exc_state_e;

endpackage

// File: rtl/exception_ctrl_arbiter.sv
// Interrupt detection and commit-event priority selection (interrupt > exception > ertn).
// Interrupts are compiled in only when EXC_CTRL_INT_EN is defined.
module exc_arbiter (
   input  logic        commit_valid_i,
   input  logic        exc_valid_i,
   input  logic        is_ertn_i,
   input  logic [11:0] ecfg_lie_i,
   input  logic [11:0] estat_is_i,
   input  logic        crmd_ie_i,
   output logic        int_pending_o,
   output logic        take_int_o,
   output logic        take_exc_o,
   output logic        take_ertn_o
);

`ifdef EXC_CTRL_INT_EN
   assign int_pending_o = crmd_ie_i & (|(ecfg_lie_i & estat_is_i));
`else
   logic unused_int;
   assign unused_int    = crmd_ie_i ^ (^ecfg_lie_i) ^ (^estat_is_i);
   assign int_pending_o = 1'b0;
`endif

   assign take_int_o  = commit_valid_i & int_pending_o;
   assign take_exc_o  = commit_valid_i & ~int_pending_o & exc_valid_i;
   assign take_ertn_o = commit_valid_i & ~int_pending_o & ~exc_valid_i & is_ertn_i;

endmodule

// File: rtl/exception_ctrl.sv
// Commit-stage exception controller: IDLE -> FLUSH -> REDIRECT event sequencing.
// Interrupt support is enabled by defining EXC_CTRL_INT_EN.
module exception_ctrl
   import exception_ctrl_pkg::*;
(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           commit_valid,
   output logic                           commit_ready,
   input  logic [31:0]                    commit_pc,
   input  logic                           commit_exc_valid,
   input  logic [ExceptionCauseWidth-1:0] commit_exc_cause,
   input  logic [31:0]                    commit_exc_addr,
   input  logic                           commit_is_ertn,
   input  logic                           commit_is_syscall_break,
   input  logic [31:0]                    eentry_va,
   input  logic [31:0]                    era_pc,
   input  logic [11:0]                    ecfg_lie,
   input  logic [11:0]                    estat_is,
   input  logic                           crmd_ie,
   output logic                           is_exception,
   output logic [ExceptionCauseWidth-1:0] exception_cause,
   output logic [31:0]                    exception_pc,
   output logic [31:0]                    exception_addr,
   output logic                           is_ertn,
   output logic                           is_syscall_break,
   output logic                           flush,
   output logic                           redirect_valid,
   output logic [31:0]                    redirect_pc,
   input  logic                           redirect_ready
);

   exc_state_e                     state_q;
   logic                           commit_ready_q;
   logic                           is_exception_q;
   logic [ExceptionCauseWidth-1:0] exception_cause_q;
   logic [31:0]                    exception_pc_q;
   logic [31:0]                    exception_addr_q;
   logic                           is_ertn_q;
   logic                           is_syscall_break_q;
   logic                           flush_q;
   logic                           redirect_valid_q;
   logic [31:0]                    redirect_pc_q;

   logic int_pending, take_int, take_exc, take_ertn;

   exc_arbiter u_arbiter (
      .commit_valid_i (commit_valid),
      .exc_valid_i    (commit_exc_valid),
      .is_ertn_i      (commit_is_ertn),
      .ecfg_lie_i     (ecfg_lie),
      .estat_is_i     (estat_is),
      .crmd_ie_i      (crmd_ie),
      .int_pending_o  (int_pending),
      .take_int_o     (take_int),
      .take_exc_o     (take_exc),
      .take_ertn_o    (take_ertn)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q            <= StIdle;
         commit_ready_q     <= 1'b1;
         is_exception_q     <= 1'b0;
         exception_cause_q  <= '0;
         exception_pc_q     <= '0;
         exception_addr_q   <= '0;
         is_ertn_q          <= 1'b0;
         is_syscall_break_q <= 1'b0;
         flush_q            <= 1'b0;
         redirect_valid_q   <= 1'b0;
         redirect_pc_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (take_int || take_exc || take_ertn) begin
                  state_q            <= StFlush;
                  commit_ready_q     <= 1'b0;
                  flush_q            <= 1'b1;
                  is_exception_q     <= take_int | take_exc;
                  is_ertn_q          <= take_ertn;
                  exception_cause_q  <= take_int ? EXCEPTION_INT :
                                        take_exc ? commit_exc_cause : '0;
                  exception_pc_q     <= (take_int || take_exc) ? commit_pc : '0;
                  exception_addr_q   <= take_exc ? commit_exc_addr : '0;
                  is_syscall_break_q <= take_exc & commit_is_syscall_break;
                  redirect_pc_q      <= take_ertn ? era_pc : eentry_va;
               end
            end
            StFlush: begin
               // Report is a one-cycle pulse; clear it so idle outputs read as zero.
               state_q            <= StRedirect;
               flush_q            <= 1'b0;
               is_exception_q     <= 1'b0;
               is_ertn_q          <= 1'b0;
               exception_cause_q  <= '0;
               exception_pc_q     <= '0;
               exception_addr_q   <= '0;
               is_syscall_break_q <= 1'b0;
               redirect_valid_q   <= 1'b1;
            end
            StRedirect: begin
               if (redirect_ready) begin
                  state_q          <= StIdle;
                  commit_ready_q   <= 1'b1;
                  redirect_valid_q <= 1'b0;
                  redirect_pc_q    <= '0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign commit_ready     = commit_ready_q;
   assign is_exception     = is_exception_q;
   assign exception_cause  = exception_cause_q;
   assign exception_pc     = exception_pc_q;
   assign exception_addr   = exception_addr_q;
   assign is_ertn          = is_ertn_q;
   assign is_syscall_break = is_syscall_break_q;
   assign flush            = flush_q;
   assign redirect_valid   = redirect_valid_q;
   assign redirect_pc      = redirect_pc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed self-checking bench for exception_ctrl (expectations follow EXC_CTRL_INT_EN).
module tb_exception_ctrl;
   import exception_ctrl_pkg::*;

   logic                           clk = 1'b0;
   logic                           rst;
   logic                           commit_valid;
   logic                           commit_ready;
   logic [31:0]                    commit_pc;
   logic                           commit_exc_valid;
   logic [ExceptionCauseWidth-1:0] commit_exc_cause;
   logic [31:0]                    commit_exc_addr;
   logic                           commit_is_ertn;
   logic                           commit_is_syscall_break;
   logic [31:0]                    eentry_va;
   logic [31:0]                    era_pc;
   logic [11:0]                    ecfg_lie;
   logic [11:0]                    estat_is;
   logic                           crmd_ie;
   logic                           is_exception;
   logic [ExceptionCauseWidth-1:0] exception_cause;
   logic [31:0]                    exception_pc;
   logic [31:0]                    exception_addr;
   logic                           is_ertn;
   logic                           is_syscall_break;
   logic                           flush;
   logic                           redirect_valid;
   logic [31:0]                    redirect_pc;
   logic                           redirect_ready;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   exception_ctrl dut (
      .clk                     (clk),
      .rst                     (rst),
      .commit_valid            (commit_valid),
      .commit_ready            (commit_ready),
      .commit_pc               (commit_pc),
      .commit_exc_valid        (commit_exc_valid),
      .commit_exc_cause        (commit_exc_cause),
      .commit_exc_addr         (commit_exc_addr),
      .commit_is_ertn          (commit_is_ertn),
      .commit_is_syscall_break (commit_is_syscall_break),
      .eentry_va               (eentry_va),
      .era_pc                  (era_pc),
      .ecfg_lie                (ecfg_lie),
      .estat_is                (estat_is),
      .crmd_ie                 (crmd_ie),
      .is_exception            (is_exception),
      .exception_cause         (exception_cause),
      .exception_pc            (exception_pc),
      .exception_addr          (exception_addr),
      .is_ertn                 (is_ertn),
      .is_syscall_break        (is_syscall_break),
      .flush                   (flush),
      .redirect_valid          (redirect_valid),
      .redirect_pc             (redirect_pc),
      .redirect_ready          (redirect_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      commit_valid            = 1'b0;
      commit_pc               = '0;
      commit_exc_valid        = 1'b0;
      commit_exc_cause        = '0;
      commit_exc_addr         = '0;
      commit_is_ertn          = 1'b0;
      commit_is_syscall_break = 1'b0;
   endtask

   // Checks that all report outputs are zero and the block is idle.
   task automatic chk_idle(input string tag);
      chk({tag, ".commit_ready"}, 32'(commit_ready), 32'd1);
      chk({tag, ".is_exception"}, 32'(is_exception), 32'd0);
      chk({tag, ".is_ertn"}, 32'(is_ertn), 32'd0);
      chk({tag, ".cause"}, 32'(exception_cause), 32'd0);
      chk({tag, ".exc_pc"}, exception_pc, 32'd0);
      chk({tag, ".flush"}, 32'(flush), 32'd0);
      chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'd0);
      chk({tag, ".redirect_pc"}, redirect_pc, 32'd0);
   endtask

   // Interrupt test: expected cause depends on build.
   task automatic int_case(input string tag, input logic ie, input logic [31:0] exp_cause,
                           input logic [31:0] exp_addr);
      crmd_ie          = ie;
      ecfg_lie         = 12'h800;
      estat_is         = 12'h800;
      commit_valid     = 1'b1;
      commit_pc        = 32'h1C000200;
      commit_exc_valid = 1'b1;
      commit_exc_cause = EXCEPTION_ALE;
      commit_exc_addr  = 32'h0000_1003;
      eentry_va        = 32'h1C008000;
      step();
      idle_inputs();
      chk({tag, ".is_exception"}, 32'(is_exception), 32'd1);
      chk({tag, ".cause"}, 32'(exception_cause), exp_cause);
      chk({tag, ".exc_pc"}, exception_pc, 32'h1C000200);
      chk({tag, ".exc_addr"}, exception_addr, exp_addr);
      step();
      chk({tag, ".redirect_pc"}, redirect_pc, 32'h1C008000);
      step();
      chk_idle({tag, ".done"});
      crmd_ie  = 1'b0;
      ecfg_lie = '0;
      estat_is = '0;
   endtask

   initial begin
      idle_inputs();
      eentry_va      = 32'h1C008000;
      era_pc         = 32'h1C000104;
      ecfg_lie       = '0;
      estat_is       = '0;
      crmd_ie        = 1'b0;
      redirect_ready = 1'b1;
      rst            = 1'b1;
      #1;
      chk_idle("reset");
      step();
      step();
      rst = 1'b0;
      chk_idle("post_reset");

      // Normal retire stays idle; stray redirect_ready has no effect.
      commit_valid = 1'b1;
      commit_pc    = 32'h1C000000;
      step();
      idle_inputs();
      chk_idle("retire");

      // Syscall exception.
      commit_valid            = 1'b1;
      commit_pc               = 32'h1C000100;
      commit_exc_valid        = 1'b1;
      commit_exc_cause        = EXCEPTION_SYS;
      commit_is_syscall_break = 1'b1;
      step();
      idle_inputs();
      chk("sys.is_exception", 32'(is_exception), 32'd1);
      chk("sys.cause", 32'(exception_cause), 32'(EXCEPTION_SYS));
      chk("sys.exc_pc", exception_pc, 32'h1C000100);
      chk("sys.sb", 32'(is_syscall_break), 32'd1);
      chk("sys.flush", 32'(flush), 32'd1);
      chk("sys.commit_ready", 32'(commit_ready), 32'd0);
      chk("sys.rv_in_flush", 32'(redirect_valid), 32'd0);
      step();
      chk("sys.is_exception_pulse", 32'(is_exception), 32'd0);
      chk("sys.flush_pulse", 32'(flush), 32'd0);
      chk("sys.redirect_valid", 32'(redirect_valid), 32'd1);
      chk("sys.redirect_pc", redirect_pc, 32'h1C008000);
      step();
      chk_idle("sys.done");

      // ertn.
      commit_valid   = 1'b1;
      commit_pc      = 32'h1C000300;
      commit_is_ertn = 1'b1;
      step();
      idle_inputs();
      chk("ertn.is_ertn", 32'(is_ertn), 32'd1);
      chk("ertn.is_exception", 32'(is_exception), 32'd0);
      chk("ertn.flush", 32'(flush), 32'd1);
      step();
      chk("ertn.is_ertn_pulse", 32'(is_ertn), 32'd0);
      chk("ertn.redirect_valid", 32'(redirect_valid), 32'd1);
      chk("ertn.redirect_pc", redirect_pc, 32'h1C000104);
      step();
      chk_idle("ertn.done");

`ifdef EXC_CTRL_INT_EN
      int_case("int_on", 1'b1, 32'(EXCEPTION_INT), 32'd0);
`else
      int_case("int_on", 1'b1, 32'(EXCEPTION_ALE), 32'h0000_1003);
`endif
      int_case("int_off", 1'b0, 32'(EXCEPTION_ALE), 32'h0000_1003);

      // Redirect back-pressure: held stable, commits ignored.
      redirect_ready   = 1'b0;
      commit_valid     = 1'b1;
      commit_pc        = 32'h1C000400;
      commit_exc_valid = 1'b1;
      commit_exc_cause = EXCEPTION_INE;
      step();
      idle_inputs();
      step();
      for (int i = 0; i < 5; i++) begin
         commit_valid   = 1'b1;
         commit_is_ertn = 1'b1;
         era_pc         = 32'h1C00_0F00;
         step();
         chk("bp.redirect_valid", 32'(redirect_valid), 32'd1);
         chk("bp.redirect_pc", redirect_pc, 32'h1C008000);
         chk("bp.commit_ready", 32'(commit_ready), 32'd0);
         chk("bp.is_ertn", 32'(is_ertn), 32'd0);
      end
      idle_inputs();
      era_pc         = 32'h1C000104;
      redirect_ready = 1'b1;
      step();
      chk_idle("bp.done");

      // Reset during FLUSH takes effect without a clock edge.
      commit_valid     = 1'b1;
      commit_pc        = 32'h1C000500;
      commit_exc_valid = 1'b1;
      commit_exc_cause = EXCEPTION_BRK;
      step();
      idle_inputs();
      chk("rstflush.flush", 32'(flush), 32'd1);
      rst = 1'b1;
      #1;
      chk_idle("rstflush");
      chk("rstflush.exc_addr", exception_addr, 32'd0);
      chk("rstflush.sb", 32'(is_syscall_break), 32'd0);
      #1;
      rst = 1'b0;
      step();
      chk_idle("rstflush.after");
      commit_valid   = 1'b1;
      commit_pc      = 32'h1C000600;
      commit_is_ertn = 1'b1;
      step();
      idle_inputs();
      chk("rstflush.next_ertn", 32'(is_ertn), 32'd1);
      step();
      chk("rstflush.next_rpc", redirect_pc, 32'h1C000104);
      step();
      chk_idle("rstflush.next_done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports are clk and rst.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 commit_valid  in  1  instruction present at commit.
REQ-005 commit_ready  out  1  commit accepted this cycle.
REQ-006 commit_pc  in  32  PC of the committing instruction.
REQ-007 commit_exc_valid / commit_exc_cause / commit_exc_addr  in  1/`ExceptionCauseWidth/32  synchronous exception attached to the instruction.
REQ-008 commit_is_ertn / commit_is_syscall_break  in  1/1  instruction is ertn / is syscall or break.
REQ-009 eentry_va / era_pc  in  32/32  exception entry and return address from the CSR file.
REQ-010 ecfg_lie / estat_is / crmd_ie  in  12/12/1  local interrupt enables, pending interrupt bits and global interrupt enable.
REQ-011 is_exception / exception_cause / exception_pc / exception_addr / is_ertn / is_syscall_break  out  1/`ExceptionCauseWidth/32/32/1/1  event report to the CSR file.
REQ-012 flush  out  1  flush all pipeline stages.
REQ-013 redirect_valid / redirect_pc / redirect_ready  out/out/in  1/32/1  fetch redirect handshake.

Function
REQ-014 int_pending SHALL equal crmd_ie & |(ecfg_lie & estat_is), evaluated combinationally.
REQ-015 The FSM states SHALL be IDLE, FLUSH and REDIRECT; commit_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, an event SHALL be taken when commit_valid=1; priority is interrupt > commit_exc_valid > commit_is_ertn. Any other commit retires normally and the state stays IDLE.
REQ-017 An interrupt SHALL report cause `EXCEPTION_INT with exception_pc=commit_pc; the instruction does not retire, and its own exception or ertn is discarded.
REQ-018 A commit exception SHALL report commit_exc_cause, commit_pc and commit_exc_addr, with is_syscall_break=commit_is_syscall_break.
REQ-019 On an event taken at edge T, the block SHALL latch redirect_pc: eentry_va for an exception or interrupt, era_pc for ertn. State becomes FLUSH.
REQ-020 In FLUSH (cycle T+1), is_exception or is_ertn SHALL be high for exactly one cycle together with the report fields, and flush=1. The next state is REDIRECT.
REQ-021 In REDIRECT, redirect_valid=1 and redirect_pc SHALL stay stable until redirect_ready=1; on that edge the state returns to IDLE.
REQ-022 Report outputs SHALL be 0 whenever is_exception and is_ertn are both 0.
REQ-023 Commit inputs and new interrupts SHALL be ignored outside IDLE; a pending interrupt is re-evaluated on the first IDLE commit.
REQ-024 redirect_ready asserted when redirect_valid=0 SHALL have no effect.
REQ-025 The minimum event-to-IDLE latency SHALL be 3 cycles when redirect_ready is held at 1.

Reset
REQ-026 rst SHALL force IDLE immediately, including mid-FLUSH and mid-REDIRECT; any in-flight redirect is abandoned.
REQ-027 During and after reset, every output SHALL be 0, except commit_ready, which is 1.

Configuration
REQ-028 The macro EXC_CTRL_INT_EN SHALL control interrupts.
- Defined: REQ-014 and REQ-017 are active.
- Undefined: int_pending is constant 0, and ecfg_lie, estat_is and crmd_ie are present but unused.
- Undefined: all other behaviour is identical.

Structure
REQ-029 The shared definitions file SHALL hold `ExceptionCauseWidth, the `EXCEPTION_* cause codes and the FSM state encoding.
REQ-030 Interrupt detection and priority selection SHALL be one combinational sub-module, exc_arbiter; the FSM and registers stay in exception_ctrl.

Verification
REQ-031 Commit pc=0x1C000100 with exc_valid=1, cause=`EXCEPTION_SYS, syscall_break=1, eentry_va=0x1C008000 -> the next cycle has is_exception=1, exception_pc=0x1C000100 and flush=1; then redirect_valid=1 with redirect_pc=0x1C008000.
REQ-032 Commit with is_ertn=1 and era_pc=0x1C000104 -> is_ertn pulses for exactly 1 cycle; redirect_pc=0x1C000104.
REQ-033 crmd_ie=1, ecfg_lie=0x800, estat_is=0x800, commit with exc_valid=1 cause=`EXCEPTION_ALE -> cause=`EXCEPTION_INT. Repeat with crmd_ie=0 -> cause=`EXCEPTION_ALE.
REQ-034 Hold redirect_ready=0 for 5 cycles in REDIRECT -> redirect_valid and redirect_pc stay stable, commit_ready=0 and commits are ignored; redirect_ready=1 -> IDLE on the next edge.
REQ-035 Assert rst in FLUSH -> all outputs 0 and commit_ready=1 with no clock edge; the next commit is processed normally.
REQ-036 Build without EXC_CTRL_INT_EN and repeat REQ-033 -> cause=`EXCEPTION_ALE.
